// File: rtl/chacha_poly_pkg.sv
// chacha_poly_pkg: shared state encoding, widths and word-index type for the Poly1305 tag finalizer
package chacha_poly_pkg;
  localparam int TAG_W = 128;
  localparam int CMP_WORDS = 4;
  localparam int WORD_W = TAG_W / CMP_WORDS;
  typedef logic [1:0] word_idx_t;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_WAIT_IN  = 3'd1;
  localparam state_t S_ADD_LO   = 3'd2;
  localparam state_t S_ADD_HI   = 3'd3;
  localparam state_t S_WAIT_EXP = 3'd4;
  localparam state_t S_CMP      = 3'd5;
  localparam state_t S_OUT      = 3'd6;
  localparam state_t S_DONE     = 3'd7;
endpackage

// File: rtl/poly_tag_ct_cmp.sv
// poly_tag_ct_cmp: constant-time tag comparator, one 32-bit word per cycle, always all four words
module poly_tag_ct_cmp
  import chacha_poly_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [TAG_W-1:0] sum,
  input  logic [TAG_W-1:0] exp,
  output logic             done,
  output logic             equal
);
  logic        run;
  logic        diff;
  word_idx_t   idx;
  logic [WORD_W-1:0] word_diff;
  assign word_diff = sum[{idx, 5'd0} +: WORD_W] ^ exp[{idx, 5'd0} +: WORD_W];
  assign done = run && idx == word_idx_t'(CMP_WORDS - 1);
  assign equal = ~(diff | (|word_diff));
  // walk the words in order, accumulating any difference without early exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run  <= 1'b0;
      idx  <= '0;
      diff <= 1'b0;
    end else if (start) begin
      run  <= 1'b1;
      idx  <= '0;
      diff <= 1'b0;
    end else if (run) begin
      diff <= diff | (|word_diff);
      idx  <= idx + 1'b1;
      if (done) run <= 1'b0;
    end
  end
endmodule

// File: rtl/chacha_poly1305_tag_finalizer.sv
// chacha_poly1305_tag_finalizer: forms tag = (acc + s) mod 2^128, emits it (encrypt) or verifies it (decrypt); optional POLY_TAG_SCRUB_EN clears secrets
module chacha_poly1305_tag_finalizer
  import chacha_poly_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             decrypt,
  input  logic [TAG_W-1:0] tag_pre_xor,
  input  logic             tag_pre_xor_valid,
  input  logic [TAG_W-1:0] tagmask,
  input  logic             tagmask_valid,
  input  logic [TAG_W-1:0] exp_tag,
  input  logic             exp_tag_valid,
  output logic             exp_tag_ready,
  output logic [TAG_W-1:0] tag_out,
  output logic             tag_out_valid,
  input  logic             tag_out_ready,
  output logic             auth_done,
  output logic             auth_pass,
  output logic             busy,
  output logic             err_proto
);
  state_t state, next;
  logic dec_q, pre_got, mask_got, exp_got, carry_q;
  logic [TAG_W-1:0] pre_q, mask_q, sum_q, exp_q, tag_q;
  logic [63:0] sum_hi;
  logic exp_hs, pre_ok, mask_ok, cmp_start, cmp_done, cmp_equal;
  assign exp_hs = exp_tag_valid && exp_tag_ready;
  assign pre_ok = pre_got || tag_pre_xor_valid;
  assign mask_ok = mask_got || tagmask_valid;
  assign sum_hi = pre_q[127:64] + mask_q[127:64] + {63'd0, carry_q};
  assign cmp_start = state != S_CMP && next == S_CMP;
  poly_tag_ct_cmp u_cmp (
    .clk   (clk),
    .rst_n (rst_n),
    .start (cmp_start),
    .sum   (sum_q),
    .exp   (exp_q),
    .done  (cmp_done),
    .equal (cmp_equal)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= next;
  end
  // next state: start aborts from anywhere and wins over same-cycle pulses
  always_comb begin
    next = state;
    if (start) next = S_WAIT_IN;
    else
      case (state)
        S_WAIT_IN:  next = (pre_ok && mask_ok) ? S_ADD_LO : S_WAIT_IN;
        S_ADD_LO:   next = S_ADD_HI;
        S_ADD_HI:   next = !dec_q ? S_OUT : (exp_got || exp_hs) ? S_CMP : S_WAIT_EXP;
        S_WAIT_EXP: next = (exp_got || exp_hs) ? S_CMP : S_WAIT_EXP;
        S_CMP:      next = cmp_done ? S_DONE : S_CMP;
        S_OUT:      next = tag_out_ready ? S_DONE : S_OUT;
        S_DONE:     next = S_IDLE;
        default:    next = S_IDLE;
      endcase
  end
  // outputs decoded from state; the computed tag only leaves the block in OUT
  always_comb begin
    busy = state != S_IDLE;
    auth_done = state == S_DONE;
    tag_out_valid = state == S_OUT;
    exp_tag_ready = dec_q && !exp_got &&
                    (state == S_WAIT_IN || state == S_ADD_LO || state == S_ADD_HI || state == S_WAIT_EXP);
`ifdef POLY_TAG_SCRUB_EN
    tag_out = tag_out_valid ? tag_q : '0;
`else
    tag_out = tag_q;
`endif
  end
  // capture, two-half addition, result and error bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q     <= 1'b0;
      pre_got   <= 1'b0;
      mask_got  <= 1'b0;
      exp_got   <= 1'b0;
      carry_q   <= 1'b0;
      pre_q     <= '0;
      mask_q    <= '0;
      sum_q     <= '0;
      exp_q     <= '0;
      tag_q     <= '0;
      auth_pass <= 1'b0;
      err_proto <= 1'b0;
    end else if (start) begin
      dec_q     <= decrypt;
      pre_got   <= 1'b0;
      mask_got  <= 1'b0;
      exp_got   <= 1'b0;
      auth_pass <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      if (state == S_WAIT_IN && tag_pre_xor_valid) begin
        if (pre_got) err_proto <= 1'b1;
        else begin
          pre_q   <= tag_pre_xor;
          pre_got <= 1'b1;
        end
      end
      if (state == S_WAIT_IN && tagmask_valid) begin
        if (mask_got) err_proto <= 1'b1;
        else begin
          mask_q   <= tagmask;
          mask_got <= 1'b1;
        end
      end
      if (exp_hs) begin
        exp_q   <= exp_tag;
        exp_got <= 1'b1;
      end
      if (state == S_ADD_LO) {carry_q, sum_q[63:0]} <= {1'b0, pre_q[63:0]} + {1'b0, mask_q[63:0]};
      if (state == S_ADD_HI) begin
        sum_q[127:64] <= sum_hi;
        if (!dec_q) tag_q <= {sum_hi, sum_q[63:0]};
      end
      if (state == S_CMP && cmp_done) begin
        auth_pass <= cmp_equal;
`ifdef POLY_TAG_SCRUB_EN
        if (!cmp_equal) exp_q <= '0;
`endif
      end
      if (state == S_OUT && tag_out_ready) auth_pass <= 1'b1;
`ifdef POLY_TAG_SCRUB_EN
      if (state == S_DONE) begin
        pre_q  <= '0;
        mask_q <= '0;
        sum_q  <= '0;
        exp_q  <= '0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_chacha_poly1305_tag_finalizer.sv
// tb_chacha_poly1305_tag_finalizer: directed self-checking bench for the Poly1305 tag finalizer
module tb_chacha_poly1305_tag_finalizer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic decrypt = 1'b0;
  logic [127:0] tag_pre_xor = '0;
  logic [127:0] tagmask = '0;
  logic [127:0] exp_tag = '0;
  logic tag_pre_xor_valid = 1'b0;
  logic tagmask_valid = 1'b0;
  logic exp_tag_valid = 1'b0;
  logic tag_out_ready = 1'b0;
  logic exp_tag_ready, tag_out_valid, auth_done, auth_pass, busy, err_proto;
  logic [127:0] tag_out;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  chacha_poly1305_tag_finalizer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .decrypt           (decrypt),
    .tag_pre_xor       (tag_pre_xor),
    .tag_pre_xor_valid (tag_pre_xor_valid),
    .tagmask           (tagmask),
    .tagmask_valid     (tagmask_valid),
    .exp_tag           (exp_tag),
    .exp_tag_valid     (exp_tag_valid),
    .exp_tag_ready     (exp_tag_ready),
    .tag_out           (tag_out),
    .tag_out_valid     (tag_out_valid),
    .tag_out_ready     (tag_out_ready),
    .auth_done         (auth_done),
    .auth_pass         (auth_pass),
    .busy              (busy),
    .err_proto         (err_proto)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic begin_msg(input logic dec);
    start = 1'b1;
    decrypt = dec;
    tick();
    start = 1'b0;
    decrypt = 1'b0;
  endtask

  task automatic pulse_inputs(input logic [127:0] pre, input logic [127:0] mask);
    tag_pre_xor = pre;
    tagmask = mask;
    tag_pre_xor_valid = 1'b1;
    tagmask_valid = 1'b1;
    tick();
    tag_pre_xor_valid = 1'b0;
    tagmask_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tests++;
    if ({busy, auth_done, auth_pass, err_proto, tag_out_valid, exp_tag_ready} !== 6'b0 || tag_out !== '0) begin
      fails++;
      $display("FAIL reset_outputs: flags=%b tag_out=%h, required all zero",
               {busy, auth_done, auth_pass, err_proto, tag_out_valid, exp_tag_ready}, tag_out);
    end
    rst_n = 1'b1;
    tick();
    begin_msg(1'b1);
    tests++;
    if ({busy, exp_tag_ready} !== 2'b11) begin
      fails++;
      $display("FAIL reset_pre_busy: busy,ready=%b required 11", {busy, exp_tag_ready});
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, exp_tag_ready} !== 2'b00) begin
      fails++;
      $display("FAIL reset_async: busy,ready=%b required 00", {busy, exp_tag_ready});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_encrypt();
    tag_out_ready = 1'b1;
    begin_msg(1'b0);
    tests++;
    if ({busy, exp_tag_ready} !== 2'b10) begin
      fails++;
      $display("FAIL enc_wait_in: busy,ready=%b required 10", {busy, exp_tag_ready});
    end
    pulse_inputs({64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 128'h1);
    tick();
    tests++;
    if (tag_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL enc_early_valid: tag_out_valid=%b at t+2 required 0", tag_out_valid);
    end
    tick();
    tests++;
    if (tag_out_valid !== 1'b1 || tag_out !== {64'h1, 64'h0}) begin
      fails++;
      $display("FAIL enc_tag: valid=%b tag=%h required 1 %h", tag_out_valid, tag_out, {64'h1, 64'h0});
    end
    tick();
    tests++;
    if ({auth_done, auth_pass, tag_out_valid} !== 3'b110) begin
      fails++;
      $display("FAIL enc_done: done,pass,valid=%b required 110", {auth_done, auth_pass, tag_out_valid});
    end
    tick();
    tests++;
    if ({auth_done, busy, auth_pass} !== 3'b001) begin
      fails++;
      $display("FAIL enc_idle: done,busy,pass=%b required 001", {auth_done, busy, auth_pass});
    end
  endtask

  task automatic test_wrap();
    tag_out_ready = 1'b0;
    begin_msg(1'b0);
    tagmask = 128'h2;
    tagmask_valid = 1'b1;
    tick();
    tagmask_valid = 1'b0;
    tick(2);
    tag_pre_xor = '1;
    tag_pre_xor_valid = 1'b1;
    tick();
    tag_pre_xor_valid = 1'b0;
    tick(2);
    tests++;
    if (tag_out_valid !== 1'b1 || tag_out !== 128'h1) begin
      fails++;
      $display("FAIL wrap_tag: valid=%b tag=%h required 1 %h", tag_out_valid, tag_out, 128'h1);
    end
    tick();
    tests++;
    if (tag_out_valid !== 1'b1 || tag_out !== 128'h1 || auth_done !== 1'b0) begin
      fails++;
      $display("FAIL wrap_hold: valid=%b tag=%h done=%b required 1 %h 0", tag_out_valid, tag_out, auth_done, 128'h1);
    end
    tag_out_ready = 1'b1;
    tick();
    tests++;
    if ({auth_done, auth_pass, tag_out_valid} !== 3'b110) begin
      fails++;
      $display("FAIL wrap_done: done,pass,valid=%b required 110", {auth_done, auth_pass, tag_out_valid});
    end
    tag_out_ready = 1'b0;
    tick();
  endtask

  task automatic test_decrypt_pass();
    logic seen;
    seen = 1'b0;
    begin_msg(1'b1);
    exp_tag = 128'h1;
    exp_tag_valid = 1'b1;
    tick();
    exp_tag_valid = 1'b0;
    tests++;
    if (exp_tag_ready !== 1'b0) begin
      fails++;
      $display("FAIL dec_ready_after_capture: exp_tag_ready=%b required 0", exp_tag_ready);
    end
    pulse_inputs('1, 128'h2);
    for (int i = 0; i < 6; i++) begin
      seen = seen | tag_out_valid | auth_done;
      tick();
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL dec_quiet: valid_or_done_seen=%b before t+7 required 0", seen);
    end
    tests++;
    if ({auth_done, auth_pass, tag_out_valid} !== 3'b110) begin
      fails++;
      $display("FAIL dec_pass: done,pass,valid=%b at t+7 required 110", {auth_done, auth_pass, tag_out_valid});
    end
    tick();
    tests++;
    if ({auth_done, auth_pass, busy} !== 3'b010) begin
      fails++;
      $display("FAIL dec_pass_hold: done,pass,busy=%b required 010", {auth_done, auth_pass, busy});
    end
  endtask

  task automatic test_decrypt_fail(input int b);
    logic [127:0] e;
    int lat;
    e = 128'h1;
    e[b] = ~e[b];
    begin_msg(1'b1);
    exp_tag = e;
    exp_tag_valid = 1'b1;
    tick();
    exp_tag_valid = 1'b0;
    pulse_inputs('1, 128'h2);
    lat = 1;
    while (!auth_done && lat < 20) begin
      tick();
      lat++;
    end
    tests++;
    if (lat !== 7 || auth_pass !== 1'b0) begin
      fails++;
      $display("FAIL dec_fail_bit%0d: latency=%0d pass=%b required 7 0", b, lat, auth_pass);
    end
    tick();
  endtask

  task automatic test_decrypt_late();
    int lat;
    begin_msg(1'b1);
    pulse_inputs(128'h5, 128'h6);
    tick(4);
    tests++;
    if ({exp_tag_ready, busy, auth_done} !== 3'b110) begin
      fails++;
      $display("FAIL late_wait_exp: ready,busy,done=%b required 110", {exp_tag_ready, busy, auth_done});
    end
    exp_tag = 128'hB;
    exp_tag_valid = 1'b1;
    tick();
    exp_tag_valid = 1'b0;
    lat = 1;
    while (!auth_done && lat < 20) begin
      tick();
      lat++;
    end
    tests++;
    if (lat !== 5 || auth_pass !== 1'b1) begin
      fails++;
      $display("FAIL late_exp: latency=%0d pass=%b required 5 1", lat, auth_pass);
    end
    tick();
  endtask

  task automatic test_protocol();
    tag_out_ready = 1'b1;
    tag_pre_xor = 128'h99;
    tag_pre_xor_valid = 1'b1;
    tick();
    tag_pre_xor_valid = 1'b0;
    tests++;
    if ({err_proto, busy} !== 2'b00) begin
      fails++;
      $display("FAIL idle_pulse_ignored: err,busy=%b required 00", {err_proto, busy});
    end
    begin_msg(1'b0);
    tag_pre_xor = 128'h10;
    tag_pre_xor_valid = 1'b1;
    tick();
    tag_pre_xor = 128'h20;
    tick();
    tag_pre_xor_valid = 1'b0;
    tests++;
    if (err_proto !== 1'b1) begin
      fails++;
      $display("FAIL dup_err: err_proto=%b required 1", err_proto);
    end
    tagmask = 128'h5;
    tagmask_valid = 1'b1;
    tick();
    tagmask_valid = 1'b0;
    tick(2);
    tests++;
    if (tag_out_valid !== 1'b1 || tag_out !== 128'h15) begin
      fails++;
      $display("FAIL dup_first_value: valid=%b tag=%h required 1 %h", tag_out_valid, tag_out, 128'h15);
    end
    tick();
    tests++;
    if ({auth_done, err_proto} !== 2'b11) begin
      fails++;
      $display("FAIL err_sticky: done,err=%b required 11", {auth_done, err_proto});
    end
    tick();
    begin_msg(1'b0);
    tests++;
    if (err_proto !== 1'b0) begin
      fails++;
      $display("FAIL err_clear: err_proto=%b required 0", err_proto);
    end
  endtask

  task automatic test_abort();
    logic seen;
    tag_out_ready = 1'b0;
    begin_msg(1'b0);
    pulse_inputs(128'h1, 128'h1);
    tick(2);
    tests++;
    if (tag_out_valid !== 1'b1 || tag_out !== 128'h2) begin
      fails++;
      $display("FAIL abort_out: valid=%b tag=%h required 1 %h", tag_out_valid, tag_out, 128'h2);
    end
    start = 1'b1;
    tag_pre_xor = 128'h100;
    tag_pre_xor_valid = 1'b1;
    tick();
    start = 1'b0;
    tag_pre_xor_valid = 1'b0;
    tests++;
    if ({tag_out_valid, auth_done, busy} !== 3'b001) begin
      fails++;
      $display("FAIL abort_drop: valid,done,busy=%b required 001", {tag_out_valid, auth_done, busy});
    end
    tag_out_ready = 1'b1;
    pulse_inputs(128'h3, 128'h4);
    seen = auth_done;
    tick();
    seen = seen | auth_done;
    tick();
    tests++;
    if (seen !== 1'b0 || tag_out_valid !== 1'b1 || tag_out !== 128'h7 || err_proto !== 1'b0) begin
      fails++;
      $display("FAIL abort_new_tag: done_seen=%b valid=%b tag=%h err=%b required 0 1 %h 0",
               seen, tag_out_valid, tag_out, err_proto, 128'h7);
    end
    tick();
    tests++;
    if ({auth_done, auth_pass} !== 2'b11) begin
      fails++;
      $display("FAIL abort_new_done: done,pass=%b required 11", {auth_done, auth_pass});
    end
    tag_out_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_wrap();
    test_decrypt_pass();
    test_decrypt_fail(0);
    test_decrypt_fail(127);
    test_decrypt_late();
    test_protocol();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
